axis_frame_arb: RTL and testbench
=================================

# axis_frame_arb

Frame-granular round-robin arbiter that multiplexes `S_COUNT` AXI-Stream sources onto one AXI-Stream master feeding the frame FIFO `axis_fifo`. A grant is held from the first beat of a frame until its `tlast` beat is accepted, so frames never interleave at the FIFO input. The output is registered, and the FIFO's `s_axis_tready` back-pressures the granted source only.

## Interface
- `S_COUNT`, 4: number of source ports, from 1 to 16.
- `DATA_WIDTH`, 8: tdata width per port.
- `KEEP_WIDTH`, `DATA_WIDTH/8`: tkeep width per port.
- `ID_WIDTH`, 8: tid width. Must be at least `$clog2(S_COUNT)` when the tag feature is compiled in.
- `DEST_WIDTH`, 8: tdest width.
- `USER_WIDTH`, 1: tuser width.
- `clk`  in  1  single clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `s_axis_tdata`  in  `S_COUNT*DATA_WIDTH`  source data, packed, port 0 in the LSBs (same packing for all `s_axis_*` vectors).
- `s_axis_tkeep`  in  `S_COUNT*KEEP_WIDTH`
- `s_axis_tvalid`  in  `S_COUNT`
- `s_axis_tready`  out  `S_COUNT`
- `s_axis_tlast`  in  `S_COUNT`
- `s_axis_tid`  in  `S_COUNT*ID_WIDTH`
- `s_axis_tdest`  in  `S_COUNT*DEST_WIDTH`
- `s_axis_tuser`  in  `S_COUNT*USER_WIDTH`
- `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tid`, `m_axis_tdest`, `m_axis_tuser`  out  per-port widths  to FIFO.
- `m_axis_tready`  in  1  from FIFO.
- `grant_idx`  out  `$clog2(S_COUNT)` (minimum 1)  currently or last granted port.
- `grant_active`  out  1  high while in ACTIVE.

## Operation
- State machine with two states, IDLE and ACTIVE.
- **IDLE:**
  - All `s_axis_tready` are 0.
  - If any `s_axis_tvalid` is high, select the first valid port scanning from `(grant_idx+1) mod S_COUNT` upward with wrap.
  - Load `grant_idx` with the selected port and go to ACTIVE.
  - If no port is valid, stay in IDLE.
- **ACTIVE:**
  - `s_axis_tready[grant_idx] = !m_axis_tvalid || m_axis_tready`. All other tready bits are 0.
  - An accepted beat (valid && ready) loads the output register with all sideband fields of the granted port and sets `m_axis_tvalid`.
  - An accepted beat with `tlast=1` returns to IDLE.
- **Output register:**
  - `m_axis_tvalid` clears when `m_axis_tready` is high and no new beat is loaded in the same cycle.
  - Simultaneous output drain and input accept gives a full-throughput pass.
- **Source stalls mid-frame** (`tvalid` low in ACTIVE): grant is held indefinitely. There is no timeout and no preemption.
- **FIFO full** (`m_axis_tready` low): the output register holds its contents, and the granted source stalls once the register is occupied.
- **All ports requesting continuously:** frames are served in order 0,1,…,S_COUNT-1,0,…
- **`S_COUNT=1`:** `grant_idx` is constantly 0; behaviour is otherwise identical.
- **Reset (including mid-frame):**
  - State returns to IDLE.
  - `grant_idx` resets to `S_COUNT-1`, so port 0 wins first.
  - All `m_axis_*` and `s_axis_tready` outputs go to 0, and `grant_active` goes to 0.
  - A truncated frame is not completed. The downstream FIFO's own reset handles cleanup.

## Timing
- With the arbiter in IDLE, `s_axis_tvalid[i]` rising in cycle N gives:
  - ACTIVE and `s_axis_tready[i]=1` in cycle N+1;
  - first beat on `m_axis_*` in cycle N+2.
- Frame boundary: the cycle after a `tlast` accept is spent in IDLE (one bubble). The next frame's first beat is accepted 2 cycles after the previous `tlast` accept.
- Within a frame with `m_axis_tready` held high: one beat per cycle, latency 1 cycle from accept to output.
- `s_axis_tready` is combinational from `m_axis_tready` and registered state only. It never depends on `s_axis_tvalid`.

## Configuration
- `AXIS_ARB_TID_TAG_EN`, defined: `m_axis_tid` = zero-extended `grant_idx` of the frame, and the source tid is discarded. Downstream can then route returned frames by port.
- `AXIS_ARB_TID_TAG_EN`, undefined: `m_axis_tid` passes through the granted source's `s_axis_tid`.

## Structure
- Package `axis_arb_pkg` holds:
  - the state encoding (`ARB_IDLE=1'b0`, `ARB_ACTIVE=1'b1`);
  - the grant-index width function (`$clog2` with minimum 1).
- Sub-module `arb_rr_select`: combinational rotating priority encoder.
  - Inputs: request vector and last grant.
  - Outputs: next grant index and `any_req`.
  - Instantiated once in `axis_frame_arb`.
- The output register and FSM live in the top module.

## Test plan
- **Reset release:** `rst` 1→0, port 0 sends a 1-beat frame with tdata=1 and tlast=1, `m_axis_tready=1` → `m_axis_tdata=1` with tlast=1 two cycles after tvalid; `grant_idx=0`.
- **Contention:** ports 0–3 each hold a 2-beat frame (tdata=0x10*i+{1,2}) → output order 0x01,0x02,0x11,0x12,0x21,0x22,0x31,0x32 with one idle bubble between frames; never interleaved.
- **Back-pressure:** `m_axis_tready=0` for 4 cycles mid-frame → output data stable, `s_axis_tready[grant]` low after one beat buffered; resumes without loss or duplication.
- **Source stall:** granted port 2 drops tvalid for 3 cycles mid-frame while port 1 is valid → grant stays 2; port 1 is served only after port 2's tlast.
- **Reset mid-frame:** `rst` asserted asynchronously during beat 2 of 4 → `m_axis_tvalid` and `s_axis_tready` go 0 immediately; after release, port 0 wins first.
- **Tag feature:** `AXIS_ARB_TID_TAG_EN` defined, port 3 sends with tid=0x55 → `m_axis_tid=3`. With the macro undefined → `m_axis_tid=0x55`.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared definitions for the frame arbiter: FSM state encoding and grant-index width helper.
package axis_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACTIVE = 1'b1
  } arb_state_t;

  // Grant index needs at least one bit even for a single source.
  function automatic int arb_gw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_rr_select.sv
// Rotating priority encoder: picks the first requester after i_last, wrapping around.
module arb_rr_select import axis_arb_pkg::*; #(
  parameter int S_COUNT = 4,
  parameter int GW      = arb_gw(S_COUNT)
) (
  input  logic [S_COUNT-1:0] i_req,
  input  logic [GW-1:0]      i_last,
  output logic [GW-1:0]      o_grant,
  output logic               o_any_req
);

  logic [GW-1:0] w_idx;

  // Scan from the lowest priority (i_last itself) up to the highest (i_last+1),
  // so the last hit written is the winner.
  always_comb begin
    o_grant   = i_last;
    o_any_req = 1'b0;
    w_idx     = '0;
    for (int k = S_COUNT; k >= 1; k--) begin
      w_idx = GW'((int'(i_last) + k) % S_COUNT);
      if (i_req[w_idx]) begin
        o_grant   = w_idx;
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_frame_arb.sv
// Frame-granular round-robin AXI-Stream arbiter with a registered output stage.
// Define AXIS_ARB_TID_TAG_EN to replace m_axis_tid with the granted port index.
module axis_frame_arb import axis_arb_pkg::*; #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*ID_WIDTH-1:0]   s_axis_tid,
  input  logic [S_COUNT*DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic [DEST_WIDTH-1:0]         m_axis_tdest,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [arb_gw(S_COUNT)-1:0]    grant_idx,
  output logic                          grant_active
);

  localparam int GW = arb_gw(S_COUNT);

  // Handshake: a beat moves when valid and ready are both high at a rising clk;
  // ready never depends on valid, and only the granted source ever sees ready.
  arb_state_t              r_state, w_next_state;
  logic [GW-1:0]           r_grant;
  logic [GW-1:0]           w_sel_grant;
  logic                    w_any_req;
  logic [S_COUNT-1:0]      w_tready;
  logic                    w_accept;

  logic [DATA_WIDTH-1:0]   r_m_tdata;
  logic [KEEP_WIDTH-1:0]   r_m_tkeep;
  logic                    r_m_tvalid;
  logic                    r_m_tlast;
  logic [ID_WIDTH-1:0]     r_m_tid;
  logic [DEST_WIDTH-1:0]   r_m_tdest;
  logic [USER_WIDTH-1:0]   r_m_tuser;

  arb_rr_select #(
    .S_COUNT (S_COUNT),
    .GW      (GW)
  ) u_sel (
    .i_req     (s_axis_tvalid),
    .i_last    (r_grant),
    .o_grant   (w_sel_grant),
    .o_any_req (w_any_req)
  );

  always_comb begin
    w_next_state = r_state;
    w_tready     = '0;
    w_accept     = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any_req) w_next_state = ARB_ACTIVE;
      end
      ARB_ACTIVE: begin
        w_tready[r_grant] = !r_m_tvalid || m_axis_tready;
        w_accept          = s_axis_tvalid[r_grant] && w_tready[r_grant];
        if (w_accept && s_axis_tlast[r_grant]) w_next_state = ARB_IDLE;
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_grant <= GW'(S_COUNT - 1);
    end else begin
      r_state <= w_next_state;
      if (r_state == ARB_IDLE && w_any_req) r_grant <= w_sel_grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tid    <= '0;
      r_m_tdest  <= '0;
      r_m_tuser  <= '0;
    end else if (w_accept) begin
      r_m_tdata  <= s_axis_tdata[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
      r_m_tkeep  <= s_axis_tkeep[int'(r_grant)*KEEP_WIDTH +: KEEP_WIDTH];
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= s_axis_tlast[r_grant];
`ifdef AXIS_ARB_TID_TAG_EN
      r_m_tid    <= ID_WIDTH'(r_grant);
`else
      r_m_tid    <= s_axis_tid[int'(r_grant)*ID_WIDTH +: ID_WIDTH];
`endif
      r_m_tdest  <= s_axis_tdest[int'(r_grant)*DEST_WIDTH +: DEST_WIDTH];
      r_m_tuser  <= s_axis_tuser[int'(r_grant)*USER_WIDTH +: USER_WIDTH];
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign s_axis_tready = w_tready;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tkeep  = r_m_tkeep;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tid    = r_m_tid;
  assign m_axis_tdest  = r_m_tdest;
  assign m_axis_tuser  = r_m_tuser;
  assign grant_idx     = r_grant;
  assign grant_active  = (r_state == ARB_ACTIVE);

endmodule

// File: tb/tb_axis_frame_arb.sv
// Bench for axis_frame_arb: directed reset/latency/tag checks, then randomized frames
// checked by a monitor against a round-robin frame-order model.
module tb_axis_frame_arb;

  localparam int S  = 4;
  localparam int EW = 27;
  localparam int MAXB = 32;
  localparam int MAXF = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [S*8-1:0] s_tdata = '0;
  logic [S-1:0]  s_tkeep = '0;
  logic [S-1:0]  s_tvalid = '0;
  logic [S-1:0]  s_tready;
  logic [S-1:0]  s_tlast = '0;
  logic [S*8-1:0] s_tid = '0;
  logic [S*8-1:0] s_tdest = '0;
  logic [S-1:0]  s_tuser = '0;
  logic [7:0]    m_tdata;
  logic          m_tkeep;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic [7:0]    m_tid;
  logic [7:0]    m_tdest;
  logic          m_tuser;
  logic [1:0]    grant_idx;
  logic          grant_active;

  int n_tests = 0;
  int n_fail  = 0;
  logic mon_en = 1'b0;
  logic [EW-1:0] exp_q[$];

  // clock/reset block
  always #5 clk = ~clk;

  axis_frame_arb dut (
    .clk (clk), .rst (rst),
    .s_axis_tdata (s_tdata), .s_axis_tkeep (s_tkeep), .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready), .s_axis_tlast (s_tlast), .s_axis_tid (s_tid),
    .s_axis_tdest (s_tdest), .s_axis_tuser (s_tuser),
    .m_axis_tdata (m_tdata), .m_axis_tkeep (m_tkeep), .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready), .m_axis_tlast (m_tlast), .m_axis_tid (m_tid),
    .m_axis_tdest (m_tdest), .m_axis_tuser (m_tuser),
    .grant_idx (grant_idx), .grant_active (grant_active)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pk(input logic [7:0] d, input logic k, input logic l,
                                       input logic [7:0] id, input logic [7:0] dst,
                                       input logic u);
    return {d, k, l, id, dst, u};
  endfunction

  // beat storage per source
  logic [7:0] b_data [S][MAXB];
  logic       b_keep [S][MAXB];
  logic       b_last [S][MAXB];
  logic       b_first[S][MAXB];
  logic [7:0] b_tid  [S][MAXB];
  logic [7:0] b_dest [S][MAXB];
  logic       b_user [S][MAXB];
  int         b_cnt[S];
  int         b_ptr[S];
  int         fr_start[S][MAXF];
  int         fr_len[S][MAXF];
  int         fr_cnt[S];

  // driver tasks
  task automatic drive_port(input int p, input logic v, input logic [7:0] d, input logic l,
                            input logic [7:0] id);
    s_tvalid[p]        = v;
    s_tdata[p*8 +: 8]  = d;
    s_tlast[p]         = l;
    s_tid[p*8 +: 8]    = id;
    s_tkeep[p]         = 1'b1;
    s_tdest[p*8 +: 8]  = 8'(p);
    s_tuser[p]         = 1'b0;
  endtask

  task automatic idle_all();
    s_tvalid = '0;
    s_tlast  = '0;
  endtask

  task automatic gen_frames();
    for (int p = 0; p < S; p++) begin
      b_cnt[p]  = 0;
      b_ptr[p]  = 0;
      fr_cnt[p] = $urandom_range(2, 4);
      for (int f = 0; f < fr_cnt[p]; f++) begin
        fr_start[p][f] = b_cnt[p];
        fr_len[p][f]   = $urandom_range(1, 4);
        for (int b = 0; b < fr_len[p][f]; b++) begin
          b_data [p][b_cnt[p]] = 8'($urandom);
          b_keep [p][b_cnt[p]] = 1'($urandom);
          b_tid  [p][b_cnt[p]] = 8'($urandom);
          b_dest [p][b_cnt[p]] = 8'($urandom);
          b_user [p][b_cnt[p]] = 1'($urandom);
          b_first[p][b_cnt[p]] = (b == 0);
          b_last [p][b_cnt[p]] = (b == fr_len[p][f] - 1);
          b_cnt[p]++;
        end
      end
    end
  endtask

  // Reference model: whole frames, served round-robin starting after port S-1.
  task automatic model_order();
    int nxt[S];
    int last_g;
    int left;
    logic found;
    logic [7:0] etid;
    last_g = S - 1;
    left = 0;
    for (int p = 0; p < S; p++) begin
      nxt[p] = 0;
      left += fr_cnt[p];
    end
    while (left > 0) begin
      found = 1'b0;
      for (int k = 1; k <= S; k++) begin
        int p;
        p = (last_g + k) % S;
        if (!found && nxt[p] < fr_cnt[p]) begin
          found = 1'b1;
          for (int b = 0; b < fr_len[p][nxt[p]]; b++) begin
            int i;
            i = fr_start[p][nxt[p]] + b;
`ifdef AXIS_ARB_TID_TAG_EN
            etid = 8'(p);
`else
            etid = b_tid[p][i];
`endif
            exp_q.push_back(pk(b_data[p][i], b_keep[p][i], b_last[p][i], etid,
                               b_dest[p][i], b_user[p][i]));
          end
          nxt[p]++;
          left--;
          last_g = p;
        end
      end
    end
  endtask

  // Monitor / scoreboard: compares every accepted output beat and checks hold under stall.
  logic          hold_pend = 1'b0;
  logic [EW-1:0] hold_val;
  initial begin
    logic [EW-1:0] got;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        got = pk(m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser);
        if (hold_pend) begin
          check("stall_valid_held", 32'(m_tvalid), 32'd1);
          check("stall_data_held", 32'(got), 32'(hold_val));
        end
        hold_pend = m_tvalid && !m_tready;
        hold_val  = got;
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(got), 32'h0);
          end else begin
            check("beat", 32'(got), 32'(exp_q.pop_front()));
          end
        end
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  task automatic run_random();
    logic [S-1:0] acc;
    logic all_done;
    int cyc;
    cyc = 0;
    all_done = 1'b0;
    while ((!all_done || exp_q.size() > 0) && cyc < 3000) begin
      @(negedge clk);
      m_tready = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < S; p++) begin
        if (b_ptr[p] < b_cnt[p]) begin
          int i;
          i = b_ptr[p];
          s_tvalid[p]       = b_first[p][i] ? 1'b1 : ($urandom_range(0, 4) != 0);
          s_tdata[p*8 +: 8] = b_data[p][i];
          s_tkeep[p]        = b_keep[p][i];
          s_tlast[p]        = b_last[p][i];
          s_tid[p*8 +: 8]   = b_tid[p][i];
          s_tdest[p*8 +: 8] = b_dest[p][i];
          s_tuser[p]        = b_user[p][i];
        end else begin
          s_tvalid[p] = 1'b0;
        end
      end
      #1;
      acc = s_tvalid & s_tready;
      check("tready_only_grant", 32'(s_tready & ~(4'b1 << grant_idx)), 32'h0);
      @(posedge clk);
      all_done = 1'b1;
      for (int p = 0; p < S; p++) begin
        if (acc[p]) b_ptr[p]++;
        if (b_ptr[p] < b_cnt[p]) all_done = 1'b0;
      end
      cyc++;
    end
    @(negedge clk);
    idle_all();
    check("random_phase_timeout", 32'(cyc < 3000), 32'd1);
  endtask

  initial begin
    int acc_n;
    int guard;
    logic a;
    // reset state
    #12;
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_grant_active", 32'(grant_active), 32'd0);
    check("rst_grant_idx", 32'(grant_idx), 32'd3);

    // reset release, single-beat frame on port 0
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_tready = 1'b1;
    drive_port(0, 1'b1, 8'h01, 1'b1, 8'h00);
    @(posedge clk); #1;
    check("first_grant_active", 32'(grant_active), 32'd1);
    check("first_tready", 32'(s_tready), 32'b0001);
    check("first_grant_idx", 32'(grant_idx), 32'd0);
    @(posedge clk); #1;
    check("first_m_tvalid", 32'(m_tvalid), 32'd1);
    check("first_m_tdata", 32'(m_tdata), 32'h01);
    check("first_m_tlast", 32'(m_tlast), 32'd1);
    check("first_back_idle", 32'(grant_active), 32'd0);
    @(negedge clk);
    idle_all();

    // tid tag on port 3
    drive_port(3, 1'b1, 8'h33, 1'b1, 8'h55);
    @(posedge clk); #1;
    check("tag_grant_idx", 32'(grant_idx), 32'd3);
    @(posedge clk); #1;
    check("tag_m_tdata", 32'(m_tdata), 32'h33);
`ifdef AXIS_ARB_TID_TAG_EN
    check("tag_m_tid", 32'(m_tid), 32'h03);
`else
    check("tag_m_tid", 32'(m_tid), 32'h55);
`endif
    @(negedge clk);
    idle_all();
    @(negedge clk);

    // reset during a 4-beat frame on port 1
    acc_n = 0;
    guard = 0;
    while (acc_n < 2 && guard < 20) begin
      @(negedge clk);
      drive_port(1, 1'b1, 8'hA0 + 8'(acc_n), 1'b0, 8'h00);
      #1;
      a = s_tvalid[1] && s_tready[1];
      @(posedge clk);
      if (a) acc_n++;
      guard++;
    end
    check("midrst_two_beats", 32'(acc_n), 32'd2);
    #1;
    check("midrst_pre_m_tvalid", 32'(m_tvalid), 32'd1);
    check("midrst_pre_m_tdata", 32'(m_tdata), 32'hA1);
    @(negedge clk);
    drive_port(1, 1'b1, 8'hA2, 1'b0, 8'h00);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("midrst_s_tready", 32'(s_tready), 32'd0);
    check("midrst_grant_active", 32'(grant_active), 32'd0);
    check("midrst_grant_idx", 32'(grant_idx), 32'd3);
    @(negedge clk);
    rst = 1'b0;
    drive_port(0, 1'b1, 8'hB0, 1'b1, 8'h00);
    @(posedge clk); #1;
    check("postrst_grant_idx", 32'(grant_idx), 32'd0);
    @(negedge clk);
    idle_all();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // randomized frames with source stalls and sink back-pressure
    for (int rep = 0; rep < 3; rep++) begin
      gen_frames();
      model_order();
      mon_en = 1'b1;
      run_random();
      repeat (4) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      mon_en = 1'b0;
      exp_q.delete();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
